// File: rtl/miner_core_sha_ctrl.sv
// miner_core_sha_ctrl: sequences msa/comp/add pulses for a SHA-256 core and chains the hash across chunks
module miner_core_sha_ctrl #(
    parameter int           MSA_CYCLES  = 48,
    parameter int           COMP_CYCLES = 64,
    parameter logic [255:0] IV          = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic [511:0] chunk_in,
    input  logic         chunk_last,
    input  logic         chunk_valid,
    output logic         chunk_ready,
    output logic         msa_en,
    output logic         comp_en,
    output logic         add_en,
    output logic [511:0] chunk,
    output logic [255:0] fh,
    input  logic [255:0] h,
    output logic [255:0] digest,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic         busy
);
    typedef enum logic [2:0] {IDLE, MSA, MSA_WAIT, COMP, COMP_WAIT, ADD, CAPT, OUT} state_t;
    state_t state, next;
    logic [6:0] cnt;
    logic last, first;
    logic [255:0] chain;
    logic accept;

    assign accept = chunk_valid && chunk_ready;
    assign fh = chain;

    always_ff @(posedge clk)
        if (!n_rst) state <= IDLE;
        else state <= next;

    always_comb begin
        next = state;
        chunk_ready = state == IDLE;
        msa_en = state == MSA;
        comp_en = state == COMP;
        add_en = state == ADD;
        digest_valid = state == OUT;
        busy = state != IDLE;
        case (state)
            IDLE:      next = accept ? MSA : IDLE;
            MSA:       next = MSA_WAIT;
            MSA_WAIT:  next = cnt == 7'(MSA_CYCLES - 1) ? COMP : MSA_WAIT;
            COMP:      next = COMP_WAIT;
            COMP_WAIT: next = cnt == 7'(COMP_CYCLES - 1) ? ADD : COMP_WAIT;
            ADD:       next = CAPT;
            CAPT:      next = last ? OUT : IDLE;
            OUT:       next = digest_ready ? IDLE : OUT;
            default:   next = IDLE;
        endcase
    end

    // counter is held at zero outside the wait states, so each wait starts from 0
    always_ff @(posedge clk)
        if (!n_rst) begin
            cnt <= '0;
            last <= 1'b0;
            first <= 1'b1;
            chain <= IV;
            chunk <= '0;
            digest <= '0;
        end else begin
            cnt <= (state == MSA_WAIT || state == COMP_WAIT) ? cnt + 7'd1 : '0;
            if (accept) begin
                chunk <= chunk_in;
                last <= chunk_last;
                if (first) chain <= IV;
            end
            if (state == CAPT) begin
                chain <= h;
                first <= last;
                if (last) digest <= h;
            end
            if (state == OUT && digest_ready) chain <= IV;
        end
endmodule

// File: tb/tb_miner_core_sha_ctrl.sv
// tb_miner_core_sha_ctrl: directed bench with a behavioural SHA-256 core answering add_en
module tb_miner_core_sha_ctrl;
    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [511:0] HELLO = {40'h68656c6c6f, 8'h80, 400'h0, 64'd40};
    localparam logic [255:0] HELLO_D = 256'h2cf24dba5fb0a30e26e83b2ac5b9e29e1b161e5c1fa7425e73043362938b9824;
    localparam logic [511:0] ABC1 = {448'h6162636462636465636465666465666765666768666768696768696a68696a6b696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f7071, 8'h80, 56'h0};
    localparam logic [511:0] ABC2 = {448'h0, 64'd448};
    localparam logic [255:0] ABC_D = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic clk = 1'b0, n_rst = 1'b0, chunk_last = 1'b0, chunk_valid = 1'b0, digest_ready = 1'b0;
    logic [511:0] chunk_in = '0;
    logic chunk_ready, msa_en, comp_en, add_en, digest_valid, busy;
    logic [511:0] chunk;
    logic [255:0] fh, h, digest;
    logic [255:0] h_core = '0;
    int errors = 0, checks = 0, excl_bad = 0;

    always #5 clk = ~clk;
    assign h = h_core;

    miner_core_sha_ctrl dut (
        .clk(clk), .n_rst(n_rst), .chunk_in(chunk_in), .chunk_last(chunk_last),
        .chunk_valid(chunk_valid), .chunk_ready(chunk_ready), .msa_en(msa_en),
        .comp_en(comp_en), .add_en(add_en), .chunk(chunk), .fh(fh), .h(h),
        .digest(digest), .digest_valid(digest_valid), .digest_ready(digest_ready), .busy(busy));

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_comp(input logic [255:0] hin, input logic [511:0] m);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
        for (int i = 0; i < 16; i++) w[i] = m[511 - 32 * i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = w[i-16] + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7]
                 + (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10));
        {a, b, c, d, e, f, g, hh} = hin;
        for (int i = 0; i < 64; i++) begin
            t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + hh};
    endfunction

    // the core's result appears on h the cycle after add_en
    always @(posedge clk) if (add_en) h_core <= sha_comp(fh, chunk);
    always @(negedge clk) if (int'(msa_en) + int'(comp_en) + int'(add_en) > 1) excl_bad++;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic run_chunk(input string tag, input logic [511:0] c, input logic l, input logic [255:0] exp_fh);
        int m_at = -1, c_at = -1, a_at = -1, v_at = -1, m_n = 0, c_n = 0, a_n = 0;
        chunk_in = c;
        chunk_last = l;
        chunk_valid = 1'b1;
        chk({tag, "_ready"}, chunk_ready, 1);
        step;
        chunk_valid = 1'b0;
        chk({tag, "_chunk"}, chunk, c);
        chk({tag, "_fh"}, fh, exp_fh);
        for (int cyc = 1; cyc <= 117; cyc++) begin
            if (msa_en) begin m_n++; m_at = cyc; end
            if (comp_en) begin c_n++; c_at = cyc; end
            if (add_en) begin a_n++; a_at = cyc; end
            if (digest_valid && v_at < 0) v_at = cyc;
            if (cyc < 117) step;
        end
        chk({tag, "_msa_at"}, m_at, 1);
        chk({tag, "_comp_at"}, c_at, 50);
        chk({tag, "_add_at"}, a_at, 115);
        chk({tag, "_en_counts"}, {m_n[7:0], c_n[7:0], a_n[7:0]}, 24'h010101);
        chk({tag, "_dv_at"}, v_at, l ? 117 : -1);
        chk({tag, "_busy_end"}, busy, l);
    endtask

    initial begin
        int bad, a_n;
        repeat (2) step;
        n_rst = 1'b1;
        chk("rst_enables", {msa_en, comp_en, add_en, digest_valid, busy}, 0);
        chk("rst_ready", chunk_ready, 1);
        chk("rst_fh", fh, IV);
        chk("rst_chunk", chunk, 0);
        chk("rst_digest", digest, 0);

        run_chunk("hello", HELLO, 1'b1, IV);
        chk("hello_digest", digest, HELLO_D);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            chunk_valid = i[0];
            chunk_in = '1;
            step;
            if (!digest_valid || digest !== HELLO_D || chunk_ready || !busy) bad++;
        end
        chunk_valid = 1'b0;
        chk("bp_stable", bad, 0);
        chk("bp_chunk_kept", chunk, HELLO);
        digest_ready = 1'b1;
        step;
        digest_ready = 1'b0;
        chk("bp_release", {digest_valid, chunk_ready, busy}, 3'b010);
        chk("bp_fh_iv", fh, IV);

        digest_ready = 1'b1;
        run_chunk("abc1", ABC1, 1'b0, IV);
        chk("abc1_idle", chunk_ready, 1);
        run_chunk("abc2", ABC2, 1'b1, sha_comp(IV, ABC1));
        chk("abc_digest", digest, ABC_D);
        step;
        digest_ready = 1'b0;
        chk("abc_idle", {digest_valid, chunk_ready}, 2'b01);
        chk("abc_fh_iv", fh, IV);

        chunk_in = HELLO;
        chunk_last = 1'b1;
        chunk_valid = 1'b1;
        step;
        chunk_valid = 1'b0;
        a_n = 0;
        for (int cyc = 1; cyc < 80; cyc++) begin
            if (add_en) a_n++;
            step;
        end
        n_rst = 1'b0;
        step;
        n_rst = 1'b1;
        chk("abort_idle", {busy, chunk_ready}, 2'b01);
        chk("abort_fh", fh, IV);
        chk("abort_digest", digest, 0);
        for (int i = 0; i < 60; i++) begin
            if (add_en) a_n++;
            step;
        end
        chk("abort_no_add", a_n, 0);
        run_chunk("hello2", HELLO, 1'b1, IV);
        chk("hello2_digest", digest, HELLO_D);
        digest_ready = 1'b1;
        step;
        digest_ready = 1'b0;
        chk("excl", excl_bad, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
